// File: rtl/scale_sequencer.sv
// Multi-cycle scaler: applies a signed x2 (saturating) or /2 (truncate toward zero)
// step once per clock, steps times, with a start/busy/done handshake and sticky ovf.
module scale_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [N:0]    op_in,
    input  logic                 sel,
    input  logic [CNT_W-1:0]     steps,
    output logic                 busy,
    output logic                 done,
    output logic signed [N:0]    result,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [N:0]  SAT_MAX = {1'b0, {N{1'b1}}};
    localparam logic signed [N:0]  SAT_MIN = {1'b1, {N{1'b0}}};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic signed [N:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic                dir;

    logic [N+1:0]        dbl;
    logic signed [N:0]   half_bias;
    logic signed [N:0]   next_acc;
    logic                step_ovf;

    // One step of the shared x2 / /2 stage applied to the accumulator.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        next_acc  = acc;
        step_ovf  = 1'b0;
        dbl       = {acc[N], acc, 1'b0} >> 1 << 1;
        dbl       = {acc, 1'b0};
        // Adding 1 to negative values before the arithmetic shift rounds toward zero.
        half_bias = acc + {{N{1'b0}}, acc[N]};
        if (dir) begin
            if (dbl[N+1] != dbl[N]) begin
                step_ovf = 1'b1;
                next_acc = dbl[N+1] ? SAT_MIN : SAT_MAX;
            end else begin
                next_acc = dbl[N:0];
            end
        end else begin
            next_acc = half_bias >>> 1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc  <= op_in;
                        dir  <= sel;
                        cnt  <= steps;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (steps == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= op_in;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    cnt <= cnt - CNT_ONE;
                    if (step_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (cnt == CNT_ONE) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= next_acc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
